// File: rtl/tx_byte_serialiser.sv
// rtl/tx_byte_serialiser.sv - byte-to-bit tx serialiser with one-byte prefetch
// Optional odd parity bit after every byte: define TX_PARITY_EN.
module tx_byte_serialiser #(
   parameter int UPSTREAM_LATENCY = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] in_data,
   input  logic [2:0] in_data_bits,
   input  logic       in_data_valid,
   output logic       in_req,
   output logic       out_data,
   output logic       out_last_bit_in_byte,
   output logic       out_data_valid,
   input  logic       out_req,
   output logic       underflow
);

   typedef enum logic [1:0] {IDLE, SEND, PARITY, STALL} state_t;

   localparam logic [3:0] PF_LOAD = 4'(UPSTREAM_LATENCY);

   state_t     state_q, state_d;
   logic [7:0] shift_q, shift_d;
   logic [3:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] buf_data_q, buf_data_d;
   logic       buf_valid_q, buf_valid_d;
   logic       eof_q, eof_d;
   logic       pf_busy_q, pf_busy_d;
   logic [3:0] pf_cnt_q, pf_cnt_d;
   logic       in_req_d, underflow_d;
   logic       out_data_d, out_last_d, out_valid_d;
`ifdef TX_PARITY_EN
   logic       par_q, par_d;
   logic       to_parity;
   logic [7:0] first_mask;
`endif

   logic       pf_land;
   logic       eff_buf_valid;
   logic       eff_eof;
   logic [7:0] eff_data;
   logic [3:0] first_cnt;
   logic       start;
   logic       shift_step;
   logic       byte_end;
   logic       boundary;
   logic       bnd_load;
   logic       bnd_eof;
   logic       bnd_under;

   // Decode of events; a prefetch landing on the same edge as a byte boundary is used directly
   always_comb begin
      pf_land       = pf_busy_q && (pf_cnt_q == 4'd1);
      eff_buf_valid = buf_valid_q | (pf_land & in_data_valid);
      eff_eof       = eof_q | (pf_land & ~in_data_valid);
      eff_data      = buf_valid_q ? buf_data_q : in_data;
      first_cnt     = (in_data_bits == 3'd0) ? 4'd8 : {1'b0, in_data_bits};
      start         = (state_q == IDLE) && in_data_valid;
      shift_step    = (state_q == SEND) && out_req && (bit_cnt_q > 4'd1);
`ifdef TX_PARITY_EN
      first_mask    = 8'hFF >> (4'd8 - first_cnt);
      to_parity     = (state_q == SEND) && out_req && (bit_cnt_q == 4'd1);
      byte_end      = (state_q == PARITY) && out_req;
`else
      byte_end      = (state_q == SEND) && out_req && (bit_cnt_q == 4'd1);
`endif
      boundary      = byte_end | ((state_q == STALL) && (eff_buf_valid | eff_eof));
      bnd_load      = boundary & eff_buf_valid;
      bnd_eof       = boundary & ~eff_buf_valid & eff_eof;
      bnd_under     = boundary & ~eff_buf_valid & ~eff_eof;
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (in_data_valid) begin
               state_d = SEND;
            end
         end
         SEND, PARITY, STALL: begin
`ifdef TX_PARITY_EN
            if (to_parity) begin
               state_d = PARITY;
            end
`endif
            if (bnd_load) begin
               state_d = SEND;
            end else if (bnd_eof) begin
               state_d = IDLE;
            end else if (bnd_under) begin
               state_d = STALL;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Next values of datapath and registered outputs; later events override earlier defaults
   always_comb begin
      shift_d     = shift_q;
      bit_cnt_d   = bit_cnt_q;
      buf_data_d  = buf_data_q;
      buf_valid_d = buf_valid_q;
      eof_d       = eof_q;
      pf_busy_d   = pf_busy_q;
      pf_cnt_d    = pf_cnt_q;
      in_req_d    = 1'b0;
      underflow_d = 1'b0;
      out_data_d  = out_data;
      out_last_d  = out_last_bit_in_byte;
      out_valid_d = out_data_valid;
`ifdef TX_PARITY_EN
      par_d       = par_q;
`endif

      if (pf_busy_q) begin
         pf_cnt_d = pf_cnt_q - 4'd1;
         if (pf_land) begin
            pf_busy_d = 1'b0;
            if (in_data_valid) begin
               buf_data_d  = in_data;
               buf_valid_d = 1'b1;
            end else begin
               eof_d = 1'b1;
            end
         end
      end

      if (start) begin
         shift_d     = in_data;
         bit_cnt_d   = first_cnt;
         out_data_d  = in_data[0];
         out_valid_d = 1'b1;
         in_req_d    = 1'b1;
         pf_busy_d   = 1'b1;
         pf_cnt_d    = PF_LOAD;
`ifdef TX_PARITY_EN
         par_d       = ~^(in_data & first_mask);
         out_last_d  = 1'b0;
`else
         out_last_d  = (first_cnt == 4'd1);
`endif
      end

      if (shift_step) begin
         shift_d    = {1'b0, shift_q[7:1]};
         bit_cnt_d  = bit_cnt_q - 4'd1;
         out_data_d = shift_q[1];
`ifdef TX_PARITY_EN
         out_last_d = 1'b0;
`else
         out_last_d = (bit_cnt_q == 4'd2);
`endif
      end

`ifdef TX_PARITY_EN
      if (to_parity) begin
         out_data_d = par_q;
         out_last_d = 1'b1;
      end
`endif

      if (bnd_load) begin
         shift_d     = eff_data;
         bit_cnt_d   = 4'd8;
         buf_valid_d = 1'b0;
         out_data_d  = eff_data[0];
         out_last_d  = 1'b0;
         in_req_d    = 1'b1;
         pf_busy_d   = 1'b1;
         pf_cnt_d    = PF_LOAD;
`ifdef TX_PARITY_EN
         par_d       = ~^eff_data;
`endif
      end

      if (bnd_eof) begin
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
         out_data_d  = 1'b0;
         eof_d       = 1'b0;
      end

      if (bnd_under) begin
         underflow_d = 1'b1;
      end
   end

   // Datapath and output registers; reset aborts any frame in progress
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q              <= 8'h00;
         bit_cnt_q            <= 4'd0;
         buf_data_q           <= 8'h00;
         buf_valid_q          <= 1'b0;
         eof_q                <= 1'b0;
         pf_busy_q            <= 1'b0;
         pf_cnt_q             <= 4'd0;
         in_req               <= 1'b0;
         underflow            <= 1'b0;
         out_data             <= 1'b0;
         out_last_bit_in_byte <= 1'b0;
         out_data_valid       <= 1'b0;
`ifdef TX_PARITY_EN
         par_q                <= 1'b0;
`endif
      end else begin
         shift_q              <= shift_d;
         bit_cnt_q            <= bit_cnt_d;
         buf_data_q           <= buf_data_d;
         buf_valid_q          <= buf_valid_d;
         eof_q                <= eof_d;
         pf_busy_q            <= pf_busy_d;
         pf_cnt_q             <= pf_cnt_d;
         in_req               <= in_req_d;
         underflow            <= underflow_d;
         out_data             <= out_data_d;
         out_last_bit_in_byte <= out_last_d;
         out_data_valid       <= out_valid_d;
`ifdef TX_PARITY_EN
         par_q                <= par_d;
`endif
      end
   end

endmodule
